mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory stage of the ARM pipeline; consumes the execute-stage outputs (wb_en, mem_r_en, mem_w_en, alu_result, val_rm_out, dest) from the EXE/MEM register.
- Performs load/store through a request/acknowledge data-memory port.
- Raises freeze to stall upstream stages while an access is outstanding.
- Registers results into the MEM/WB boundary and provides the MEM-stage forwarding value that feeds mem_val of the execute stage.

Parameters:
- ADDR_BASE, 1024: byte address mapped to memory word 0.
- ADDR_W, 16: word-address width on the memory port.
- TIMEOUT_CYCLES, 255: ack wait limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wb_en_in  in  1  writeback enable from EXE
- mem_r_en_in  in  1  load request
- mem_w_en_in  in  1  store request
- alu_result  in  32  effective byte address, or ALU value for non-memory instructions
- val_rm  in  32  store data
- dest_in  in  4  destination register
- mem_req  out  1  memory request, level, held until ack
- mem_we  out  1  1 = write, valid with mem_req
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  store data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  read data, valid with mem_ack
- freeze  out  1  stall upstream (PC, IF/ID, ID/EXE, EXE/MEM hold)
- fwd_val  out  32  combinational alu_result, drives EXE mem_val
- wb_en  out  1  registered to WB
- mem_r_en  out  1  registered, selects memory data in WB
- alu_result_out  out  32  registered
- mem_data  out  32  registered load data
- dest  out  4  registered
- mem_err  out  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN

Behaviour:
- Address: mem_addr = ((alu_result - ADDR_BASE) mod 2^32)[ADDR_W+1:2]. Low two bits are ignored; values below ADDR_BASE wrap and are not flagged.
- req_in = mem_r_en_in | mem_w_en_in.
- If both mem_r_en_in and mem_w_en_in are set, the access is a write; mem_rdata is not captured and mem_r_en is output as 0.
- FSM states:
  - IDLE: if req_in, go to ACCESS; mem_req rises on the next cycle.
  - ACCESS: mem_req=1. mem_we/mem_addr/mem_wdata are registered on the IDLE->ACCESS edge and held stable. On mem_ack, capture mem_rdata into an internal buffer and go to DONE.
  - DONE: one cycle, mem_req=0, then IDLE.
- freeze = req_in & (state != DONE), combinational. Non-memory instructions never freeze.
- Output register, updated every clock edge:
  - freeze=0: load wb_en_in, mem_r_en_in & ~mem_w_en_in, alu_result, buffered data (load) or 0, dest_in.
  - freeze=1: load a bubble: wb_en=0, mem_r_en=0, other fields 0. This prevents duplicate writeback.
- Latency:
  - Non-memory instruction: 1 cycle to outputs.
  - Memory access: 3 + N cycles, where N is the number of cycles from mem_req to mem_ack (N≥0 counting the ack cycle as 0 extra).
- mem_ack outside ACCESS is ignored.
- mem_ack in the same cycle mem_req first rises is valid (completes in 1 cycle).
- Reset (rst=0, any time, including mid-ACCESS): state IDLE; mem_req, mem_we, freeze-internal state, all registered outputs, the buffer and mem_err all go to 0. An ack arriving after reset release is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When the count reaches TIMEOUT_CYCLES, go to DONE with the buffer set to 0 and mem_err set; mem_err is sticky until reset.
- Not defined: ACCESS waits indefinitely for ack; mem_err is tied to 0 and no counter exists.

Test Plan:
- Reset then non-memory op (wb_en_in=1, alu_result=0x1234, dest_in=3) -> next cycle wb_en=1, alu_result_out=0x1234, dest=3, freeze never 1.
- Load with alu_result=1032, ack 2 cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=2, mem_we=0, freeze high until DONE, then mem_data=0xDEADBEEF, mem_r_en=1, wb_en=1 exactly once; bubbles (wb_en=0) during freeze.
- Store with alu_result=1028, val_rm=0xA5A5A5A5, ack same cycle as mem_req -> mem_we=1, mem_addr=1, mem_wdata=0xA5A5A5A5, freeze high 2 cycles, mem_r_en=0.
- Assert rst=0 mid-ACCESS then release, and ack on the following cycle -> mem_req=0, all outputs 0, no writeback, FSM stays IDLE.
- Both enables set, alu_result=1024 -> write issued to mem_addr=0, mem_r_en=0 at output.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> after 4 ACCESS cycles mem_err=1, mem_data=0, freeze released; mem_err stays 1 on later accesses.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Memory stage of the ARM pipeline. Takes the EXE/MEM register contents,
// performs loads and stores over a request/acknowledge data-memory port,
// stalls the upstream stages while an access is outstanding, and registers
// the result into the MEM/WB boundary.
//
// Optional feature: define MEM_TIMEOUT_EN to abandon an access after
// TIMEOUT_CYCLES cycles without an acknowledge and raise a sticky mem_err.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous reset, active-low
//   wb_en_in       in   writeback enable from EXE
//   mem_r_en_in    in   load request
//   mem_w_en_in    in   store request (wins over a simultaneous load)
//   alu_result     in   effective byte address or ALU value [31:0]
//   val_rm         in   store data [31:0]
//   dest_in        in   destination register [3:0]
//   mem_req        out  memory request, held until mem_ack
//   mem_we         out  1 = write, valid with mem_req
//   mem_addr       out  word address [ADDR_W-1:0]
//   mem_wdata      out  store data [31:0]
//   mem_ack        in   one-cycle completion pulse
//   mem_rdata      in   read data, valid with mem_ack [31:0]
//   freeze         out  stall PC, IF/ID, ID/EXE and EXE/MEM
//   fwd_val        out  MEM-stage forwarding value for the execute stage
//   wb_en          out  registered writeback enable
//   mem_r_en       out  registered, selects memory data in WB
//   alu_result_out out  registered ALU result
//   mem_data       out  registered load data
//   dest           out  registered destination register
//   mem_err        out  sticky timeout flag (0 without MEM_TIMEOUT_EN)

module mem_access_stage #(
  parameter int ADDR_BASE      = 1024,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       val_rm,
  input  logic [3:0]        dest_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              freeze,
  output logic [31:0]       fwd_val,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [31:0]       alu_result_out,
  output logic [31:0]       mem_data,
  output logic [3:0]        dest,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        req_in;
  logic        is_load;
  logic        start;
  logic        complete;
  logic [31:0] offset;
  logic [31:0] rd_buf;
  logic        addr_unused;

  // A store wins when both enables are set, so only a pure load returns data.
  assign req_in  = mem_r_en_in | mem_w_en_in;
  assign is_load = mem_r_en_in & ~mem_w_en_in;

  // Byte addresses below ADDR_BASE wrap around silently; only the word
  // index bits reach the memory port.
  assign offset      = alu_result - 32'(ADDR_BASE);
  assign addr_unused = ^{offset[1:0], offset[31:ADDR_W+2]};

  assign mem_req = (state == ACCESS);
  // DONE is the one cycle where the instruction is allowed to move on.
  assign freeze  = req_in & (state != DONE);
  assign fwd_val = alu_result;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             err_q;

  // Counts ACCESS cycles that passed without an acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (start) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !mem_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_err = err_q;
`else
  logic timeout_unused;

  assign timeout_unused = |TIMEOUT_CYCLES;
  assign mem_err        = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the start/complete strobes for the datapath.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    complete   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timed_out  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_in) begin
          next_state = ACCESS;
          start      = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          next_state = DONE;
          complete   = 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        // The current cycle is the TIMEOUT_CYCLES-th one without an ack.
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          next_state = DONE;
          timed_out  = 1'b1;
        end
`endif
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Memory port registers are captured once on entry to ACCESS so they stay
  // stable for the whole access; read data is buffered until DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_buf    <= '0;
    end else begin
      if (start) begin
        mem_we    <= mem_w_en_in;
        mem_addr  <= offset[ADDR_W+1:2];
        mem_wdata <= val_rm;
      end
      if (complete) begin
        rd_buf <= mem_we ? 32'h0 : mem_rdata;
      end
`ifdef MEM_TIMEOUT_EN
      if (timed_out) begin
        rd_buf <= 32'h0;
      end
`endif
    end
  end

  // MEM/WB register: while frozen a bubble is inserted so the stalled
  // instruction is written back exactly once, on its final cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en          <= 1'b0;
      mem_r_en       <= 1'b0;
      alu_result_out <= '0;
      mem_data       <= '0;
      dest           <= '0;
    end else if (freeze) begin
      wb_en          <= 1'b0;
      mem_r_en       <= 1'b0;
      alu_result_out <= '0;
      mem_data       <= '0;
      dest           <= '0;
    end else begin
      wb_en          <= wb_en_in;
      mem_r_en       <= is_load;
      alu_result_out <= alu_result;
      mem_data       <= is_load ? rd_buf : 32'h0;
      dest           <= dest_in;
    end
  end

endmodule
